// File: rtl/ct_hpcp_cnt_chan_if.sv
// HPCP counter channel CSR/event bundle.
// master: CSR/event source; slave: counter channel.
interface ct_hpcp_cnt_chan_if #(
  parameter int EVT_NUM = 64,
  parameter int SEL_W   = 6,
  parameter int ADD_W   = 4,
  parameter int CNT_W   = 64
);
  logic [EVT_NUM*ADD_W-1:0] evt_adder_bus;
  logic                     evt_sel_wen;
  logic [SEL_W-1:0]         evt_sel_wdata;
  logic                     cnt_wen;
  logic [CNT_W-1:0]         cnt_wdata;
  logic                     cnt_inhibit;
  logic                     ovf_clr;
  logic [SEL_W-1:0]         evt_sel;
  logic [CNT_W-1:0]         cnt_value;
  logic                     ovf_pulse;
  logic                     ovf_sticky;

  modport master (
    output evt_adder_bus, evt_sel_wen,
    output evt_sel_wdata, cnt_wen,
    output cnt_wdata, cnt_inhibit, ovf_clr,
    input  evt_sel, cnt_value,
    input  ovf_pulse, ovf_sticky
  );

  modport slave (
    input  evt_adder_bus, evt_sel_wen,
    input  evt_sel_wdata, cnt_wen,
    input  cnt_wdata, cnt_inhibit, ovf_clr,
    output evt_sel, cnt_value,
    output ovf_pulse, ovf_sticky
  );
endinterface

// File: rtl/ct_hpcp_cnt_chan.sv
// HPCP counter channel: registered event select + accumulator.
// Ports: forever_cpuclk, cpurst (async high), bus (slave).
// Optional HPCP_CNT_SATURATE_EN: saturate instead of wrap.
module ct_hpcp_cnt_chan #(
  parameter int EVT_NUM = 64,
  parameter int SEL_W   = 6,
  parameter int ADD_W   = 4,
  parameter int CNT_W   = 64
) (
  input logic              forever_cpuclk,
  input logic              cpurst,
  ct_hpcp_cnt_chan_if.slave bus
);

  logic [SEL_W-1:0] sel_q;
  logic [ADD_W-1:0] add_q;
  logic [ADD_W-1:0] sel_add;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             sticky_q;
  logic [CNT_W:0]   sum;
  logic             carry;
  logic             acc_en;

  // Out-of-range selectors match no slice and yield 0.
  always_comb begin
    sel_add = '0;
    for (int k = 0; k < EVT_NUM; k++) begin
      if (sel_q == SEL_W'(k))
        sel_add = bus.evt_adder_bus[k*ADD_W +: ADD_W];
    end
  end

  assign acc_en = ~bus.cnt_wen & ~bus.cnt_inhibit;
  assign sum = {1'b0, cnt_q}
             + {{(CNT_W+1-ADD_W){1'b0}}, add_q};
  assign carry = sum[CNT_W] & acc_en;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      sel_q <= '0;
      add_q <= '0;
    end else begin
      if (bus.evt_sel_wen)
        sel_q <= bus.evt_sel_wdata;
      // Drop stale/held increments on reselect or inhibit.
      if (bus.evt_sel_wen | bus.cnt_inhibit)
        add_q <= '0;
      else
        add_q <= sel_add;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (bus.cnt_wen) begin
        cnt_q <= bus.cnt_wdata;
      end else if (acc_en) begin
`ifdef HPCP_CNT_SATURATE_EN
        if (carry) begin
          cnt_q   <= '1;
          pulse_q <= ~&cnt_q;
        end else begin
          cnt_q <= sum[CNT_W-1:0];
        end
`else
        cnt_q   <= sum[CNT_W-1:0];
        pulse_q <= carry;
`endif
      end
      if (carry)
        sticky_q <= 1'b1;
      else if (bus.ovf_clr)
        sticky_q <= 1'b0;
    end
  end

  assign bus.evt_sel    = sel_q;
  assign bus.cnt_value  = cnt_q;
  assign bus.ovf_pulse  = pulse_q;
  assign bus.ovf_sticky = sticky_q;

endmodule

// File: tb/tb_ct_hpcp_cnt_chan.sv
// Directed bench for ct_hpcp_cnt_chan.
// Expected values hand-derived; honours HPCP_CNT_SATURATE_EN.
module tb_ct_hpcp_cnt_chan;
  localparam int EN = 52;
  localparam int SW = 6;
  localparam int AW = 4;
  localparam int CW = 64;
`ifdef HPCP_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [CW-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] e;

  always #5 clk = ~clk;

  ct_hpcp_cnt_chan_if #(
    .EVT_NUM(EN), .SEL_W(SW),
    .ADD_W(AW), .CNT_W(CW)
  ) bus ();

  ct_hpcp_cnt_chan #(
    .EVT_NUM(EN), .SEL_W(SW),
    .ADD_W(AW), .CNT_W(CW)
  ) dut (
    .forever_cpuclk(clk),
    .cpurst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h exp %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_evt(input int k,
                         input logic [AW-1:0] v);
    bus.evt_adder_bus[k*AW +: AW] = v;
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, "_sel"}, 64'(bus.evt_sel), 0);
    chk({tag, "_cnt"}, bus.cnt_value, 0);
    chk({tag, "_pls"}, 64'(bus.ovf_pulse), 0);
    chk({tag, "_stk"}, 64'(bus.ovf_sticky), 0);
  endtask

  initial begin
    bus.evt_adder_bus = '0;
    bus.evt_sel_wen   = 1'b0;
    bus.evt_sel_wdata = '0;
    bus.cnt_wen       = 1'b0;
    bus.cnt_wdata     = '0;
    bus.cnt_inhibit   = 1'b0;
    bus.ovf_clr       = 1'b0;
    #12;
    chk_all0("rst");
    @(negedge clk);
    rst = 1'b0;

    // Select event 5, others busy but ignored.
    bus.evt_sel_wen   = 1'b1;
    bus.evt_sel_wdata = 6'd5;
    tick();
    bus.evt_sel_wen = 1'b0;
    chk("sel5", 64'(bus.evt_sel), 5);
    set_evt(0, 4'd7);
    set_evt(6, 4'd9);
    set_evt(5, 4'd3);
    tick();
    chk("lat1", bus.cnt_value, 0);
    tick();
    chk("lat2", bus.cnt_value, 3);
    tick();
    chk("acc3", bus.cnt_value, 6);
    tick();
    chk("acc4", bus.cnt_value, 9);
    bus.evt_adder_bus = '0;
    tick();
    chk("acc12", bus.cnt_value, 12);
    tick();
    chk("hold12", bus.cnt_value, 12);

    // Overflow from 2^64-2 + 3.
    bus.cnt_wen   = 1'b1;
    bus.cnt_wdata = ONES - 64'd1;
    set_evt(5, 4'd3);
    tick();
    chk("wr", bus.cnt_value, ONES - 64'd1);
    bus.cnt_wen = 1'b0;
    bus.evt_adder_bus = '0;
    tick();
    e = SAT ? ONES : 64'd1;
    chk("ovf_cnt", bus.cnt_value, e);
    chk("ovf_pls", 64'(bus.ovf_pulse), 1);
    chk("ovf_stk", 64'(bus.ovf_sticky), 1);
    tick();
    chk("pls_1cyc", 64'(bus.ovf_pulse), 0);
    set_evt(5, 4'd3);
    tick();
    bus.evt_adder_bus = '0;
    tick();
    e = SAT ? ONES : 64'd4;
    chk("more_cnt", bus.cnt_value, e);
    chk("more_pls", 64'(bus.ovf_pulse), 0);
    chk("more_stk", 64'(bus.ovf_sticky), 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("clr_stk", 64'(bus.ovf_sticky), 0);

    // Out-of-range selector plus same-cycle counter write.
    bus.evt_adder_bus = '1;
    bus.evt_sel_wen   = 1'b1;
    bus.evt_sel_wdata = 6'd63;
    bus.cnt_wen       = 1'b1;
    bus.cnt_wdata     = 64'd50;
    tick();
    bus.evt_sel_wen = 1'b0;
    bus.cnt_wen     = 1'b0;
    chk("sel63", 64'(bus.evt_sel), 63);
    chk("both_wr", bus.cnt_value, 50);
    tick();
    tick();
    tick();
    chk("oor_cnt", bus.cnt_value, 50);
    chk("oor_pls", 64'(bus.ovf_pulse), 0);
    chk("oor_stk", 64'(bus.ovf_sticky), 0);

    // Counter write discards in-flight increment.
    bus.evt_adder_bus = '0;
    bus.evt_sel_wen   = 1'b1;
    bus.evt_sel_wdata = 6'd5;
    tick();
    bus.evt_sel_wen = 1'b0;
    set_evt(5, 4'd4);
    tick();
    bus.evt_adder_bus = '0;
    bus.cnt_wen   = 1'b1;
    bus.cnt_wdata = 64'd100;
    tick();
    bus.cnt_wen = 1'b0;
    chk("wr_win", bus.cnt_value, 100);
    tick();
    chk("wr_noadd", bus.cnt_value, 100);

    // Overflow with same-cycle ovf_clr: set wins.
    bus.cnt_wen   = 1'b1;
    bus.cnt_wdata = ONES - 64'd1;
    set_evt(5, 4'd2);
    tick();
    bus.cnt_wen = 1'b0;
    bus.evt_adder_bus = '0;
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    e = SAT ? ONES : 64'd0;
    chk("sc_cnt", bus.cnt_value, e);
    chk("sc_pls", 64'(bus.ovf_pulse), 1);
    chk("sc_stk", 64'(bus.ovf_sticky), 1);

    // Inhibit holds and leaves no residue.
    bus.cnt_wen   = 1'b1;
    bus.cnt_wdata = 64'd0;
    set_evt(5, 4'd2);
    tick();
    bus.cnt_wen     = 1'b0;
    bus.cnt_inhibit = 1'b1;
    tick();
    chk("inh1", bus.cnt_value, 0);
    tick();
    tick();
    chk("inh3", bus.cnt_value, 0);
    bus.cnt_inhibit = 1'b0;
    tick();
    chk("rel1", bus.cnt_value, 0);
    tick();
    chk("rel2", bus.cnt_value, 2);
    tick();
    chk("rel3", bus.cnt_value, 4);

    // Asynchronous reset mid-run.
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all0("arst");
    set_evt(0, 4'd5);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post1", bus.cnt_value, 0);
    tick();
    chk("post2", bus.cnt_value, 5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/ct_hpcp_cnt_chan.md
Name: ct_hpcp_cnt_chan

Overview:
Parametrised hardware performance counter channel. It generalises the flat fixed-width event-adder select into a registered select stage feeding an accumulating counter. Selection covers a configurable event count and adder width, and the channel adds inhibit, software write and overflow tracking. One instance is placed per mhpmcounter in the HPCP, between the per-unit event adder collectors and the CSR read path.

Parameters:
EVT_NUM, 64, number of selectable event sources (event 0 .. EVT_NUM-1)
SEL_W, 6, width of event selector; must satisfy 2^SEL_W >= EVT_NUM
ADD_W, 4, width of each per-cycle event increment
CNT_W, 64, counter width

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  asynchronous active-high reset
evt_adder_bus  in  EVT_NUM*ADD_W  packed event increments; event k at [k*ADD_W +: ADD_W]
evt_sel_wen  in  1  write strobe for event selector (mhpmevent CSR write)
evt_sel_wdata  in  SEL_W  new selector value
cnt_wen  in  1  write strobe for counter value (mhpmcounter CSR write)
cnt_wdata  in  CNT_W  new counter value
cnt_inhibit  in  1  mcountinhibit bit for this channel; 1 = hold
ovf_clr  in  1  clear sticky overflow flag
evt_sel  out  SEL_W  current selector register
cnt_value  out  CNT_W  current counter value
ovf_pulse  out  1  single-cycle overflow indication
ovf_sticky  out  1  sticky overflow flag

Behaviour:
- Reset values: evt_sel=0, cnt_value=0, ovf_pulse=0, ovf_sticky=0, internal adder stage add_q=0.
- Stage 1 (select):
  - add_q <= evt_adder_bus slice indexed by evt_sel.
  - evt_sel >= EVT_NUM selects 0, never X.
- Stage 2 (accumulate), one cycle after stage 1. Total latency from event to cnt_value is 2 cycles.
- Selector write:
  - evt_sel <= evt_sel_wdata on evt_sel_wen.
  - add_q is forced to 0 in the write cycle, so no stale increment from the old event is added.
  - The first increment from the new event is registered the cycle after the write.
- Counter update priority, highest first:
  1. cnt_wen: cnt_value <= cnt_wdata. The in-flight add_q is discarded and no overflow is raised.
  2. cnt_inhibit=1: hold. add_q is also forced to 0 in the next cycle, so no residue appears after un-inhibit.
  3. Otherwise: cnt_value <= cnt_value + zero-extended add_q.
- Arithmetic:
  - Sum is computed in CNT_W+1 bits; the carry-out is the overflow condition.
  - Default (feature off): wrap modulo 2^CNT_W.
- Overflow:
  - On carry-out, ovf_pulse=1 for exactly one cycle, registered with the new cnt_value.
  - ovf_sticky is set on carry-out.
  - ovf_clr clears ovf_sticky; if set and clear occur in the same cycle, set wins.
  - ovf_pulse returns to 0 the following cycle unless another carry occurs.
- add_q=0 leaves cnt_value unchanged and raises no overflow.
- Simultaneous evt_sel_wen and cnt_wen are both applied independently.
- Reset asserted mid-accumulation returns all state to reset values immediately (asynchronous). The first count after deassertion uses evt_sel=0.

Optional Feature:
Macro HPCP_CNT_SATURATE_EN.
- Defined:
  - On carry-out, cnt_value is held at all-ones instead of wrapping.
  - ovf_pulse is asserted only on the first transition into saturation; ovf_sticky is set.
  - Further increments at all-ones produce no pulse.
- Undefined: wrap-around behaviour as above. No saturation logic is compiled.

Test Plan:
- Reset, then evt_sel_wdata=5 with wen, then drive event5=3 for 4 cycles -> cnt_value reaches 12, with the first increment visible 2 cycles after event5 is driven; other events ignored.
- cnt_wdata=2^64-2, event adder=3 -> cnt_value=1, ovf_pulse high 1 cycle, ovf_sticky=1.
  - Same scenario with HPCP_CNT_SATURATE_EN defined -> cnt_value=all-ones, single pulse.
  - Same scenario with HPCP_CNT_SATURATE_EN defined, further adds -> no further pulses.
- evt_sel_wdata=63 with EVT_NUM=52 and all events=0xF -> cnt_value unchanged, no X on any output.
- Same cycle: cnt_wen with cnt_wdata=100 and nonzero add_q in flight -> cnt_value=100 next cycle, no add. Same-cycle ovf_clr and overflow -> ovf_sticky stays 1.
- cnt_inhibit=1 for 3 cycles with event adder=2 -> cnt_value constant. After release, first increment appears 2 cycles later; no residual add. Assert cpurst mid-run -> all outputs 0 immediately.
